// File: rtl/data_memory_banked_pkg.sv
// Shared definitions for the banked data memory: access-size encodings,
// default region bases and the big-endian byte-lane mask helper.
package data_mem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_RSVD = 2'b10,
    SIZE_WORD = 2'b11
  } mem_size_e;

  localparam logic [15:0] STACK_BASE  = 16'h7fff;
  localparam logic [15:0] DATA_BASE   = 16'h1000;
  localparam logic [15:0] SERIAL_BASE = 16'hffff;

  // Lane k of the mask covers bits [8k+7:8k]; byte offset 0 is the MSB lane.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] mask;
    mask = 4'b0000;
    case (size)
      SIZE_BYTE: mask = 4'b1000 >> offset;
      SIZE_HALF: mask = offset[1] ? 4'b0011 : 4'b1100;
      SIZE_WORD: mask = 4'b1111;
      default:   mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/mem_bank_sync.sv
// One RAM region: 2^AW words of 32 bits, per-byte write enables and a
// registered read port that keeps its last value while rd_en is low.
module mem_bank_sync #(
  parameter int AW = 10
) (
  input  logic          clock,
  input  logic          rd_en,
  input  logic [3:0]    wr_en,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  // Byte-lane writes and the registered read share one clocked process.
  always_ff @(posedge clock) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en[b]) begin
        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (rd_en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_memory_banked.sv
// Data-memory address-space wrapper: decodes requests onto N_REGIONS RAM
// banks, checks alignment, returns one response per request and keeps a
// sticky first-fault address plus a saturating fault counter.
module data_memory_banked
  import data_mem_pkg::*;
#(
  parameter int                      N_REGIONS   = 2,
  parameter logic [16*N_REGIONS-1:0] REGION_BASE = {STACK_BASE, DATA_BASE},
  parameter int                      REGION_AW   = 10,
  parameter int                      ERR_CNT_W   = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid_in,
  output logic                 req_ready_out,
  input  logic                 req_we_in,
  input  logic [31:0]          req_addr_in,
  input  logic [1:0]           req_size_in,
  input  logic [31:0]          req_wdata_in,
  output logic                 resp_valid_out,
  input  logic                 resp_ready_in,
  output logic [31:0]          resp_rdata_out,
  output logic                 resp_err_out,
  output logic                 fault_valid_out,
  output logic [31:0]          fault_addr_out,
  input  logic                 fault_clear_in,
  output logic [ERR_CNT_W-1:0] err_count_out
);

  logic        accept;
  logic        hit;
  logic [2:0]  hit_idx;
  logic        fault;
  logic [3:0]  wr_mask;
  logic [31:0] wr_data;

  logic        resp_is_read;
  logic [1:0]  resp_off;
  logic [1:0]  resp_size;
  logic [2:0]  resp_idx;
  logic [31:0] sel_word;
  logic [31:0] read_data;

  logic [31:0] bank_rdata [N_REGIONS];

  assign req_ready_out = !resp_valid_out || resp_ready_in;
  assign accept        = req_valid_in && req_ready_out;

  // Region decode (lowest matching index wins), fault detection and lane steering.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 3'd0;
    for (int i = N_REGIONS - 1; i >= 0; i--) begin
      if (req_addr_in[31:16] == REGION_BASE[16*i +: 16]) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
      end
    end
    fault = !hit
         || (req_size_in == SIZE_RSVD)
         || ((req_size_in == SIZE_HALF) && req_addr_in[0])
         || ((req_size_in == SIZE_WORD) && (req_addr_in[1:0] != 2'b00));
    wr_mask = lane_mask(req_size_in, req_addr_in[1:0]);
    case (req_size_in)
      SIZE_BYTE: wr_data = {4{req_wdata_in[7:0]}};
      SIZE_HALF: wr_data = {2{req_wdata_in[15:0]}};
      default:   wr_data = req_wdata_in;
    endcase
  end

  for (genvar g = 0; g < N_REGIONS; g++) begin : g_bank
    logic bank_sel;
    assign bank_sel = accept && !fault && (hit_idx == 3'(g));

    mem_bank_sync #(.AW(REGION_AW)) u_bank (
      .clock (clock),
      .rd_en (bank_sel && !req_we_in),
      .wr_en ((bank_sel && req_we_in) ? wr_mask : 4'b0000),
      .addr  (req_addr_in[REGION_AW+1:2]),
      .wdata (wr_data),
      .rdata (bank_rdata[g])
    );
  end

  // Response slot: filled on accept, emptied when consumed without a refill.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp_valid_out <= 1'b0;
      resp_err_out   <= 1'b0;
      resp_is_read   <= 1'b0;
      resp_off       <= 2'b00;
      resp_size      <= 2'b00;
      resp_idx       <= 3'd0;
    end else if (accept) begin
      resp_valid_out <= 1'b1;
      resp_err_out   <= fault;
      resp_is_read   <= !req_we_in && !fault;
      resp_off       <= req_addr_in[1:0];
      resp_size      <= req_size_in;
      resp_idx       <= hit_idx;
    end else if (resp_ready_in) begin
      resp_valid_out <= 1'b0;
    end
  end

  // Pick the bank that served the read and extract its big-endian lanes.
  always_comb begin
    sel_word = 32'd0;
    for (int i = 0; i < N_REGIONS; i++) begin
      if (resp_idx == 3'(i)) begin
        sel_word = bank_rdata[i];
      end
    end
    case (resp_size)
      SIZE_BYTE: read_data = {24'd0, sel_word[{~resp_off, 3'b000} +: 8]};
      SIZE_HALF: read_data = {16'd0, sel_word[{~resp_off[1], 4'b0000} +: 16]};
      default:   read_data = sel_word;
    endcase
    resp_rdata_out = resp_is_read ? read_data : 32'd0;
  end

  // Fault bookkeeping: clear beats capture, but the counter always counts.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fault_valid_out <= 1'b0;
      fault_addr_out  <= 32'd0;
      err_count_out   <= '0;
    end else begin
      if (accept && fault && (err_count_out != {ERR_CNT_W{1'b1}})) begin
        err_count_out <= err_count_out + 1'b1;
      end
      if (fault_clear_in) begin
        fault_valid_out <= 1'b0;
        fault_addr_out  <= 32'd0;
      end else if (accept && fault && !fault_valid_out) begin
        fault_valid_out <= 1'b1;
        fault_addr_out  <= req_addr_in;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_banked.sv
// Self-checking bench for data_memory_banked: directed scenarios followed by
// randomized traffic compared against a byte-addressed reference model.
module tb_data_memory_banked;

  localparam int NREG = 3;
  localparam logic [16*NREG-1:0] BASES = {16'h1000, 16'h7fff, 16'h1000};

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid_in;
  logic        req_ready_out;
  logic        req_we_in;
  logic [31:0] req_addr_in;
  logic [1:0]  req_size_in;
  logic [31:0] req_wdata_in;
  logic        resp_valid_out;
  logic        resp_ready_in;
  logic [31:0] resp_rdata_out;
  logic        resp_err_out;
  logic        fault_valid_out;
  logic [31:0] fault_addr_out;
  logic        fault_clear_in;
  logic [3:0]  err_count_out;

  data_memory_banked #(
    .N_REGIONS   (NREG),
    .REGION_BASE (BASES),
    .REGION_AW   (10),
    .ERR_CNT_W   (4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid_in    (req_valid_in),
    .req_ready_out   (req_ready_out),
    .req_we_in       (req_we_in),
    .req_addr_in     (req_addr_in),
    .req_size_in     (req_size_in),
    .req_wdata_in    (req_wdata_in),
    .resp_valid_out  (resp_valid_out),
    .resp_ready_in   (resp_ready_in),
    .resp_rdata_out  (resp_rdata_out),
    .resp_err_out    (resp_err_out),
    .fault_valid_out (fault_valid_out),
    .fault_addr_out  (fault_addr_out),
    .fault_clear_in  (fault_clear_in),
    .err_count_out   (err_count_out)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clock) cyc++;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  // Reference model state: memory as individual bytes keyed by region/byte.
  logic [15:0] tb_bases [NREG] = '{16'h1000, 16'h7fff, 16'h1000};
  logic [7:0]  m_mem [int];
  resp_t       m_q [$];
  logic        m_pending = 1'b0;
  logic        m_fv = 1'b0;
  logic [31:0] m_fa = 32'd0;
  int          m_cnt = 0;
  logic [31:0] last_rdata;
  logic        last_err;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int region_of(input logic [31:0] a);
    for (int i = 0; i < NREG; i++) begin
      if (a[31:16] == tb_bases[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_access(input logic we, input logic [31:0] a, input logic [1:0] sz,
                              input logic [31:0] wd, output resp_t r);
    int ri;
    int n;
    int base;
    ri = region_of(a);
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    r.err = (ri < 0) || (sz == 2'b10) || (sz == 2'b01 && a[0]) || (sz == 2'b11 && a[1:0] != 2'b00);
    r.rdata = 32'd0;
    if (!r.err) begin
      base = ri * 65536 + int'(a[11:2]) * 4 + int'(a[1:0]);
      for (int j = 0; j < n; j++) begin
        if (we) begin
          m_mem[base + j] = wd[8*(n-1-j) +: 8];
        end else begin
          r.rdata = (r.rdata << 8) | {24'd0, (m_mem.exists(base + j) ? m_mem[base + j] : 8'h00)};
        end
      end
    end
  endtask

  // Monitor: compares the DUT against the model every cycle, then advances the model.
  always @(negedge clock) begin
    resp_t r;
    logic  acc;
    if (!reset) begin
      m_q.delete();
      m_pending = 1'b0;
      m_fv = 1'b0;
      m_fa = 32'd0;
      m_cnt = 0;
    end else begin
      check_output("resp_valid", 32'(resp_valid_out), 32'(m_pending));
      check_output("req_ready", 32'(req_ready_out), 32'(!m_pending || resp_ready_in));
      check_output("fault_valid", 32'(fault_valid_out), 32'(m_fv));
      check_output("fault_addr", fault_addr_out, m_fa);
      check_output("err_count", 32'(err_count_out), 32'(m_cnt));
      if (m_pending && m_q.size() > 0) begin
        check_output("resp_rdata", resp_rdata_out, m_q[0].rdata);
        check_output("resp_err", 32'(resp_err_out), 32'(m_q[0].err));
        if (resp_ready_in) begin
          last_rdata = resp_rdata_out;
          last_err   = resp_err_out;
          void'(m_q.pop_front());
        end
      end
      acc = req_valid_in && (!m_pending || resp_ready_in);
      r.err = 1'b0;
      if (acc) begin
        model_access(req_we_in, req_addr_in, req_size_in, req_wdata_in, r);
        m_q.push_back(r);
        if (r.err && m_cnt != 15) m_cnt++;
      end
      if (fault_clear_in) begin
        m_fv = 1'b0;
        m_fa = 32'd0;
      end else if (acc && r.err && !m_fv) begin
        m_fv = 1'b1;
        m_fa = req_addr_in;
      end
      if (acc) m_pending = 1'b1;
      else if (resp_ready_in) m_pending = 1'b0;
    end
  end

  // Presents one request (caller is just after a rising edge) until accepted.
  task automatic apply_stimulus(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                input logic [31:0] wdata);
    int waited;
    logic done;
    waited = 0;
    done = 1'b0;
    req_we_in = we;
    req_addr_in = addr;
    req_size_in = size;
    req_wdata_in = wdata;
    req_valid_in = 1'b1;
    while (!done) begin
      @(negedge clock);
      if (req_ready_out) done = 1'b1;
      else begin
        waited++;
        if (waited > 200) begin
          check_output("accept_timeout", 32'd0, 32'd1);
          done = 1'b1;
        end
      end
    end
    @(posedge clock);
    #1;
    req_valid_in = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(posedge clock);
      n++;
    end while (m_pending && n < 100);
    if (m_pending) check_output("idle_timeout", 32'd1, 32'd0);
    #1;
  endtask

  task automatic random_request();
    int pick;
    logic [15:0] hi;
    logic [1:0] sz;
    logic [1:0] off;
    pick = $urandom_range(0, 9);
    hi = (pick < 4) ? 16'h1000 : (pick < 8) ? 16'h7fff : (pick == 8) ? 16'h2000 : 16'hffff;
    sz = 2'($urandom_range(0, 3));
    off = 2'($urandom_range(0, 3));
    if ($urandom_range(0, 4) != 0) begin
      if (sz == 2'b11) off = 2'b00;
      else if (sz == 2'b01) off = off & 2'b10;
    end
    req_we_in = 1'($urandom_range(0, 1));
    req_addr_in = {hi, 4'($urandom_range(0, 15)), 7'd0, 3'($urandom_range(0, 7)), off};
    req_size_in = sz;
    req_wdata_in = $urandom;
  endtask

  initial begin
    #500000;
    failures++;
    $display("[TB] FAIL watchdog expired at t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int start;
    logic acc;
    req_valid_in = 1'b0;
    req_we_in = 1'b0;
    req_addr_in = 32'd0;
    req_size_in = 2'b00;
    req_wdata_in = 32'd0;
    resp_ready_in = 1'b1;
    fault_clear_in = 1'b0;
    last_rdata = 32'd0;
    last_err = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    check_output("rst_resp_valid", 32'(resp_valid_out), 32'd0);
    check_output("rst_resp_err", 32'(resp_err_out), 32'd0);
    check_output("rst_fault_valid", 32'(fault_valid_out), 32'd0);
    check_output("rst_fault_addr", fault_addr_out, 32'd0);
    check_output("rst_err_count", 32'(err_count_out), 32'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;

    $display("[TB] word and byte lane accesses");
    apply_stimulus(1'b1, 32'h10000010, 2'b11, 32'hDEADBEEF);
    apply_stimulus(1'b0, 32'h10000010, 2'b11, 32'd0);
    wait_idle();
    check_output("word_rd", last_rdata, 32'hDEADBEEF);
    check_output("word_rd_err", 32'(last_err), 32'd0);
    apply_stimulus(1'b1, 32'h10000011, 2'b00, 32'h000000AA);
    apply_stimulus(1'b0, 32'h10000010, 2'b11, 32'd0);
    wait_idle();
    check_output("byte_merge", last_rdata, 32'hDEAABEEF);
    apply_stimulus(1'b0, 32'h10000012, 2'b01, 32'd0);
    wait_idle();
    check_output("half_rd", last_rdata, 32'h0000BEEF);
    apply_stimulus(1'b0, 32'h10000011, 2'b00, 32'd0);
    wait_idle();
    check_output("byte_rd", last_rdata, 32'h000000AA);

    $display("[TB] faults and fault clear");
    apply_stimulus(1'b1, 32'h7fff0000, 2'b11, 32'h01234567);
    apply_stimulus(1'b0, 32'h20000000, 2'b11, 32'd0);
    apply_stimulus(1'b1, 32'h7fff0001, 2'b01, 32'h0000FFFF);
    wait_idle();
    check_output("fault_err", 32'(last_err), 32'd1);
    check_output("fault_valid_set", 32'(fault_valid_out), 32'd1);
    check_output("fault_addr_first", fault_addr_out, 32'h20000000);
    check_output("err_count_two", 32'(err_count_out), 32'd2);
    fault_clear_in = 1'b1;
    @(posedge clock);
    #1;
    fault_clear_in = 1'b0;
    check_output("clr_fault_valid", 32'(fault_valid_out), 32'd0);
    check_output("clr_fault_addr", fault_addr_out, 32'd0);
    check_output("clr_err_count", 32'(err_count_out), 32'd2);
    apply_stimulus(1'b0, 32'h7fff0000, 2'b11, 32'd0);
    wait_idle();
    check_output("no_ram_change", last_rdata, 32'h01234567);
    apply_stimulus(1'b0, 32'h7fff1000, 2'b11, 32'd0);
    wait_idle();
    check_output("wrap_rd", last_rdata, 32'h01234567);

    $display("[TB] stall and back-to-back");
    resp_ready_in = 1'b0;
    apply_stimulus(1'b0, 32'h10000010, 2'b11, 32'd0);
    start = cyc;
    fork
      apply_stimulus(1'b0, 32'h10000012, 2'b01, 32'd0);
      begin
        repeat (5) @(posedge clock);
        #1;
        check_output("stall_ready", 32'(req_ready_out), 32'd0);
        check_output("stall_rdata", resp_rdata_out, 32'hDEAABEEF);
        resp_ready_in = 1'b1;
      end
    join
    check_output("stall_cycles", 32'(cyc - start), 32'd6);
    start = cyc;
    apply_stimulus(1'b0, 32'h10000010, 2'b11, 32'd0);
    apply_stimulus(1'b0, 32'h10000013, 2'b00, 32'd0);
    apply_stimulus(1'b0, 32'h10000010, 2'b01, 32'd0);
    apply_stimulus(1'b0, 32'h7fff0000, 2'b11, 32'd0);
    check_output("b2b_cycles", 32'(cyc - start), 32'd4);
    wait_idle();

    $display("[TB] randomized traffic");
    for (int r = 0; r < 2; r++) begin
      for (int w = 0; w < 8; w++) begin
        apply_stimulus(1'b1, {(r == 0) ? 16'h1000 : 16'h7fff, 11'd0, 3'(w), 2'b00}, 2'b11, $urandom);
      end
    end
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      acc = req_valid_in && req_ready_out;
      @(posedge clock);
      #1;
      resp_ready_in = ($urandom_range(0, 3) != 0);
      fault_clear_in = ($urandom_range(0, 19) == 0);
      if (!req_valid_in || acc) begin
        if ($urandom_range(0, 3) != 0) begin
          random_request();
          req_valid_in = 1'b1;
        end else begin
          req_valid_in = 1'b0;
        end
      end
    end
    resp_ready_in = 1'b1;
    fault_clear_in = 1'b0;
    @(negedge clock);
    @(posedge clock);
    #1;
    req_valid_in = 1'b0;
    wait_idle();

    $display("[TB] reset during a stalled response");
    apply_stimulus(1'b0, 32'h20000000, 2'b11, 32'd0);
    wait_idle();
    check_output("pre_rst_fault_valid", 32'(fault_valid_out), 32'd1);
    resp_ready_in = 1'b0;
    apply_stimulus(1'b1, 32'h10000020, 2'b11, 32'hCAFEF00D);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check_output("async_resp_valid", 32'(resp_valid_out), 32'd0);
    check_output("async_resp_err", 32'(resp_err_out), 32'd0);
    check_output("async_fault_valid", 32'(fault_valid_out), 32'd0);
    check_output("async_fault_addr", fault_addr_out, 32'd0);
    check_output("async_err_count", 32'(err_count_out), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    resp_ready_in = 1'b1;
    @(posedge clock);
    #1;
    apply_stimulus(1'b0, 32'h10000020, 2'b11, 32'd0);
    wait_idle();
    check_output("post_rst_rd", last_rdata, 32'hCAFEF00D);
    check_output("post_rst_err", 32'(last_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_memory_banked.md
Name: data_memory_banked

Overview:
- Parametrised successor to the processor's data-memory address-space wrapper.
- Decodes a 32-bit address onto N_REGIONS synchronous RAM regions, each selected by the upper 16 address bits.
- Supports byte, halfword and word reads and writes with alignment checking, behind a valid/ready request/response handshake with 1-cycle read latency.
- Latches the first fault address and counts faults for debug; sits between the pipeline's memory stage and the memory banks.

Parameters:
- N_REGIONS, 2, number of RAM regions (1..8).
- REGION_BASE, {16'h7fff,16'h1000}, packed N_REGIONS x 16-bit vector of addr[31:16] match values; region i uses bits [16*i+15:16*i].
- REGION_AW, 10, log2 of words per region (default 10 = 4 KB per region).
- ERR_CNT_W, 8, width of the fault counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset.
- req_valid_in  in  1  request present.
- req_ready_out  out  1  request accepted on this edge when high together with req_valid_in.
- req_we_in  in  1  1 = write, 0 = read.
- req_addr_in  in  32  byte address.
- req_size_in  in  2  00 = byte, 01 = halfword, 11 = word, 10 = reserved.
- req_wdata_in  in  32  write data, right-justified.
- resp_valid_out  out  1  response present.
- resp_ready_in  in  1  consumer takes the response.
- resp_rdata_out  out  32  read data, right-justified and zero-extended; 0 for writes and errors.
- resp_err_out  out  1  the request faulted.
- fault_valid_out  out  1  sticky: a fault has been captured.
- fault_addr_out  out  32  address of the first fault since clear.
- fault_clear_in  in  1  clears fault_valid_out and fault_addr_out.
- err_count_out  out  ERR_CNT_W  saturating count of faulted requests.

Behaviour:
- Reset (reset = 0, asynchronous): resp_valid_out = 0, resp_err_out = 0, fault_valid_out = 0, fault_addr_out = 0, err_count_out = 0. RAM contents are not reset and are undefined.
- Handshake: req_ready_out = !resp_valid_out || resp_ready_in. This is a one-deep pipeline: a new request is accepted in the same cycle a pending response is consumed.
- Accept edge (req_valid_in && req_ready_out): resp_valid_out is set the following cycle; resp_err_out and resp_rdata_out stay stable until the response is consumed.
- Stall: resp_valid_out holds while !resp_ready_in. RAM read enable is asserted only on the accept edge, so RAM output is frozen during a stall.
- Decode: region i is selected when addr[31:16] == REGION_BASE[i]. If several regions match, the lowest index wins. Word index = addr[REGION_AW+1:2]; addr[15:REGION_AW+2] are ignored, so accesses wrap within the region.
- Faults, any of:
  - no region matches (unmapped);
  - size 10;
  - halfword with addr[0] = 1;
  - word with addr[1:0] != 0.
  A faulted request does not write RAM, returns rdata 0 and err = 1, and still produces exactly one response.
- Byte lanes are big-endian (MIPS):
  - byte offset 0 maps to bits [31:24], offset 3 to [7:0];
  - halfword offset 0 maps to [31:16], offset 2 to [15:0].
  A write updates only the addressed lanes from the low bits of req_wdata_in. A read extracts the lanes using the offset/size registered at accept, then zero-extends; sign extension is the processor's job.
- Write commits at the accept edge; the write response has rdata = 0, err = 0.
- Hazards: a read accepted on the edge after a write to the same word returns the new data. There is no same-edge read/write conflict, because one request is accepted per edge.
- Fault capture: on an accepted faulted request, if fault_valid_out = 0, latch the address and set fault_valid_out. err_count_out increments and saturates at all-ones.
- fault_clear_in clears fault_valid_out and fault_addr_out. If a fault is accepted in the same cycle as fault_clear_in, clear wins for fault_valid/addr, but err_count still increments. The counter clears only on reset.
- Reset mid-stall: the pending response is dropped and the RAM write (if already committed) remains.

Decomposition:
- Package data_mem_pkg: size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD), default region-base constants (STACK_BASE = 16'h7fff, DATA_BASE = 16'h1000, SERIAL_BASE = 16'hffff, reserved), and the lane-mask function (size, offset) -> 4-bit byte enable.
- Sub-module mem_bank_sync: one region, 2^REGION_AW x 32 with 4 byte-write enables and a read enable. It has a registered output that holds when the read enable is low, and is instantiated N_REGIONS times via generate.

Test Plan:
- Word write 0xDEADBEEF at 0x10000010, then word read at the same address -> resp_rdata 0xDEADBEEF, err 0, response 1 cycle after accept.
- Byte write 0xAA at 0x10000011, then word read at 0x10000010 -> 0xDEAABEEF. Halfword read at 0x10000012 -> 0x0000BEEF. Byte read at 0x10000011 -> 0x000000AA.
- Word read at 0x20000000 (unmapped), then halfword write at 0x7fff0001 -> both err = 1, no RAM change, fault_addr 0x20000000, err_count 2. fault_clear_in pulsed -> fault_valid 0, err_count stays 2.
- Hold resp_ready_in low for 5 cycles after a read -> req_ready_out 0, rdata stable. Raise resp_ready_in with the next request present -> accepted the same cycle, back-to-back throughput of 1 per cycle.
- Wrap: word write at 0x7fff0000, read at 0x7fff1000 (REGION_AW = 10) -> same data. With overlapping REGION_BASE entries -> region 0 is used.
- Assert reset low while resp_valid_out = 1 -> all outputs 0 immediately, without waiting for a clock edge. After release, the first request behaves normally.
